// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default instruction/address widths, the NOP encoding
// and the instruction-memory controller state encoding.
package cpu_pkg;

  localparam int INST_W      = 32;
  localparam int IMEM_ADDR_W = 6;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IMEM_BOOT = 2'd0,
    IMEM_IDLE = 2'd1,
    IMEM_WAIT = 2'd2
  } imem_state_e;

  // Width of the fetch wait-state counter; WAIT_CYC must fit (0..15).
  localparam int IMEM_WAIT_W = 4;

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Fetch (request/valid) and program-load bus between a CPU core and inst_mem_ctrl.
// master = core side, slave = memory side.
interface inst_mem_ctrl_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INST_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rdy;
  logic              if_valid;
  logic [DATA_W-1:0] if_inst;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_rdy;

  modport master (
    output if_req, if_addr, ld_we, ld_addr, ld_data,
    input  if_rdy, if_valid, if_inst, ld_rdy
  );

  modport slave (
    input  if_req, if_addr, ld_we, ld_addr, ld_data,
    output if_rdy, if_valid, if_inst, ld_rdy
  );

endinterface

// File: rtl/inst_mem_ctrl_imem_array.sv
// Plain block-RAM style storage: one write port, one registered read port.
// A same-edge read and write to one address returns the old word.
module imem_array #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Synchronous instruction memory with boot-clear, program-load port and a
// wait-state fetch handshake. Define IMEM_PARITY_EN to store and check even parity.
module inst_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = INST_W,
  parameter int                WAIT_CYC = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_INST
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_mem_ctrl_if.slave bus,
  output logic           busy,
  output logic           par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  imem_state_e             state_reg, state_next;
  logic [ADDR_W-1:0]       clr_cnt_reg, clr_cnt_next;
  logic [IMEM_WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [ADDR_W-1:0]       addr_reg, addr_next;
  logic                    if_valid_reg;
  logic                    inst_seen_reg;

  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [MEM_W-1:0]        mem_wword;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [MEM_W-1:0]        rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IMEM_BOOT;
      clr_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      addr_reg      <= '0;
      if_valid_reg  <= 1'b0;
      inst_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      addr_reg      <= addr_next;
      if_valid_reg  <= rd_en;
      if (rd_en) begin
        inst_seen_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    addr_next     = addr_reg;
    mem_we        = 1'b0;
    mem_waddr     = bus.ld_addr;
    mem_wdata     = bus.ld_data;
    rd_en         = 1'b0;
    rd_addr       = bus.if_addr;

    case (state_reg)
      IMEM_BOOT: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = NOP_WORD;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = IMEM_IDLE;
        end
      end

      IMEM_IDLE: begin
        mem_we = bus.ld_we;
        if (bus.if_req) begin
          addr_next = bus.if_addr;
          if (WAIT_CYC == 0) begin
            rd_en = 1'b1;
          end else begin
            state_next    = IMEM_WAIT;
            wait_cnt_next = IMEM_WAIT_W'(WAIT_CYC);
          end
        end
      end

      IMEM_WAIT: begin
        // The fetch is committed once accepted; if_req is not looked at here.
        mem_we        = bus.ld_we;
        rd_addr       = addr_reg;
        wait_cnt_next = wait_cnt_reg - 1'b1;
        if (wait_cnt_reg == IMEM_WAIT_W'(1)) begin
          rd_en      = 1'b1;
          state_next = IMEM_IDLE;
        end
      end

      default: begin
        state_next = IMEM_BOOT;
      end
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign mem_wword = {^mem_wdata, mem_wdata};
`else
  assign mem_wword = mem_wdata;
`endif

  imem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (MEM_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wword),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  assign busy         = (state_reg == IMEM_BOOT);
  assign bus.ld_rdy   = (state_reg != IMEM_BOOT);
  assign bus.if_rdy   = (state_reg == IMEM_IDLE);
  assign bus.if_valid = if_valid_reg;
  // The array read register is not reset, so present NOP until the first fetch.
  assign bus.if_inst  = inst_seen_reg ? rd_word[DATA_W-1:0] : NOP_WORD;

`ifdef IMEM_PARITY_EN
  logic par_bad;
  logic par_err_reg;

  assign par_bad = if_valid_reg && (^rd_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_reg <= 1'b0;
    end else if (par_bad) begin
      par_err_reg <= 1'b1;
    end
  end

  assign par_err = par_err_reg | par_bad;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed bench for inst_mem_ctrl: one instance with no wait states, one with three.
module tb_inst_mem_ctrl;

  logic clk;
  logic rst_n;
  logic busy0, busy3, perr0, perr3;
  int   n_cmp;
  int   n_err;

  inst_mem_ctrl_if #(.ADDR_W(6), .DATA_W(32)) b0 ();
  inst_mem_ctrl_if #(.ADDR_W(6), .DATA_W(32)) b3 ();

  inst_mem_ctrl #(.ADDR_W(6), .DATA_W(32), .WAIT_CYC(0), .NOP_WORD(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0), .par_err(perr0)
  );

  inst_mem_ctrl #(.ADDR_W(6), .DATA_W(32), .WAIT_CYC(3), .NOP_WORD(32'h0)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3), .par_err(perr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_boot(input string name);
    int n;
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 64) begin
      n_err++;
      $display("FAIL %s: busy cycles got %0d want 64", name, n);
    end
    n_cmp++;
    if (busy3 !== 1'b0 || b3.if_rdy !== 1'b1 || b0.if_rdy !== 1'b1 || b0.ld_rdy !== 1'b1 || b3.ld_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: busy3=%b rdy0=%b rdy3=%b ldrdy0=%b ldrdy3=%b want 0 1 1 1 1",
               name, busy3, b0.if_rdy, b3.if_rdy, b0.ld_rdy, b3.ld_rdy);
    end
    $display("boot %s: busy for %0d cycles", name, n);
  endtask

  task automatic load0(input logic [5:0] a, input logic [31:0] d);
    b0.ld_we = 1'b1; b0.ld_addr = a; b0.ld_data = d;
    tick();
    b0.ld_we = 1'b0;
    $display("load dut0 [%02h] = %08h", a, d);
  endtask

  task automatic load3(input logic [5:0] a, input logic [31:0] d);
    b3.ld_we = 1'b1; b3.ld_addr = a; b3.ld_data = d;
    tick();
    b3.ld_we = 1'b0;
    $display("load dut3 [%02h] = %08h", a, d);
  endtask

  task automatic fetch0(input logic [5:0] a, input logic [31:0] exp, input string name);
    b0.if_req = 1'b1; b0.if_addr = a;
    tick();
    b0.if_req = 1'b0;
    n_cmp++;
    if (b0.if_valid !== 1'b1 || b0.if_inst !== exp) begin
      n_err++;
      $display("FAIL %s: valid=%b inst=%08h want valid=1 inst=%08h", name, b0.if_valid, b0.if_inst, exp);
    end
    $display("fetch dut0 [%02h] -> %08h (%s)", a, b0.if_inst, name);
  endtask

  task automatic fetch3(input logic [5:0] a, input logic [31:0] exp, input string name);
    int n;
    b3.if_req = 1'b1; b3.if_addr = a;
    tick();
    b3.if_req = 1'b0;
    n = 1;
    while (b3.if_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 4 || b3.if_inst !== exp) begin
      n_err++;
      $display("FAIL %s: latency=%0d inst=%08h want latency=4 inst=%08h", name, n, b3.if_inst, exp);
    end
    $display("fetch dut3 [%02h] -> %08h after %0d cycles (%s)", a, b3.if_inst, n, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b0.if_req = 1'b0; b0.if_addr = '0; b0.ld_we = 1'b0; b0.ld_addr = '0; b0.ld_data = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.ld_we = 1'b0; b3.ld_addr = '0; b3.ld_data = '0;
    #2;
    n_cmp++;
    if (b0.if_rdy !== 1'b0 || b0.if_valid !== 1'b0 || b0.if_inst !== 32'h0 || b0.ld_rdy !== 1'b0
        || busy0 !== 1'b1 || perr0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals: rdy=%b valid=%b inst=%08h ldrdy=%b busy=%b perr=%b want 0 0 0 0 1 0",
               b0.if_rdy, b0.if_valid, b0.if_inst, b0.ld_rdy, busy0, perr0);
    end
    tick();
    tick();
    // Requests during boot must be ignored.
    b0.if_req = 1'b1; b0.if_addr = 6'h3F;
    rst_n = 1'b1;
    $display("reset released");
    wait_boot("boot0");
    b0.if_req = 1'b0;
    n_cmp++;
    if (b0.if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL boot_ignore_req: valid=%b want 0", b0.if_valid);
    end
    fetch0(6'h3F, 32'h0, "fetch_3f");
  endtask

  task automatic test_back_to_back();
    load0(6'h01, 32'h28033046);
    load0(6'h02, 32'h00101464);
    b0.if_req = 1'b1; b0.if_addr = 6'h01;
    tick();
    n_cmp++;
    if (b0.if_valid !== 1'b1 || b0.if_inst !== 32'h28033046 || b0.if_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: valid=%b inst=%08h rdy=%b want 1 28033046 1", b0.if_valid, b0.if_inst, b0.if_rdy);
    end
    $display("b2b fetch 01 -> %08h", b0.if_inst);
    b0.if_addr = 6'h02;
    tick();
    b0.if_req = 1'b0;
    n_cmp++;
    if (b0.if_valid !== 1'b1 || b0.if_inst !== 32'h00101464) begin
      n_err++;
      $display("FAIL b2b_second: valid=%b inst=%08h want 1 00101464", b0.if_valid, b0.if_inst);
    end
    $display("b2b fetch 02 -> %08h", b0.if_inst);
    tick();
    n_cmp++;
    if (b0.if_valid !== 1'b0 || b0.if_inst !== 32'h00101464) begin
      n_err++;
      $display("FAIL b2b_hold: valid=%b inst=%08h want 0 00101464", b0.if_valid, b0.if_inst);
    end
  endtask

  task automatic test_wait_states();
    load3(6'h05, 32'h3c000c21);
    b3.if_req = 1'b1; b3.if_addr = 6'h05;
    tick();
    b3.if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (b3.if_rdy !== 1'b0 || b3.if_valid !== 1'b0) begin
        n_err++;
        $display("FAIL wait_cycle%0d: rdy=%b valid=%b want 0 0", i, b3.if_rdy, b3.if_valid);
      end
      $display("wait cycle %0d: rdy=%b valid=%b", i, b3.if_rdy, b3.if_valid);
      tick();
    end
    n_cmp++;
    if (b3.if_valid !== 1'b1 || b3.if_rdy !== 1'b1 || b3.if_inst !== 32'h3c000c21) begin
      n_err++;
      $display("FAIL wait_resp: valid=%b rdy=%b inst=%08h want 1 1 3c000c21", b3.if_valid, b3.if_rdy, b3.if_inst);
    end
    tick();
    n_cmp++;
    if (b3.if_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wait_pulse: valid=%b want 0", b3.if_valid);
    end
  endtask

  task automatic test_same_edge();
    b0.ld_we = 1'b1; b0.ld_addr = 6'h0A; b0.ld_data = 32'h04100841;
    b0.if_req = 1'b1; b0.if_addr = 6'h0A;
    tick();
    b0.ld_we = 1'b0; b0.if_req = 1'b0;
    n_cmp++;
    if (b0.if_valid !== 1'b1 || b0.if_inst !== 32'h0) begin
      n_err++;
      $display("FAIL same_edge_old: valid=%b inst=%08h want 1 00000000", b0.if_valid, b0.if_inst);
    end
    $display("same-edge fetch 0a -> %08h", b0.if_inst);
    fetch0(6'h0A, 32'h04100841, "same_edge_new");
  endtask

  task automatic test_parity();
`ifdef IMEM_PARITY_EN
    logic [32:0] w;
    w = dut0.u_array.mem[2];
    w[0] = ~w[0];
    dut0.u_array.mem[2] = w;
    fetch0(6'h02, 32'h00101465, "par_data");
    n_cmp++;
    if (perr0 !== 1'b1) begin
      n_err++;
      $display("FAIL par_flag: par_err=%b want 1", perr0);
    end
    fetch0(6'h3F, 32'h0, "par_clean");
    tick();
    n_cmp++;
    if (perr0 !== 1'b1) begin
      n_err++;
      $display("FAIL par_sticky: par_err=%b want 1", perr0);
    end
`else
    fetch0(6'h02, 32'h00101464, "nopar_data");
    n_cmp++;
    if (perr0 !== 1'b0 || perr3 !== 1'b0) begin
      n_err++;
      $display("FAIL par_tied: par_err0=%b par_err3=%b want 0 0", perr0, perr3);
    end
`endif
    $display("parity check: par_err0=%b", perr0);
  endtask

  task automatic test_reset_mid_wait();
    load3(6'h01, 32'h28033046);
    fetch3(6'h01, 32'h28033046, "pre_reset_fetch");
    b3.if_req = 1'b1; b3.if_addr = 6'h01;
    tick();
    b3.if_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy3 !== 1'b1 || b3.if_valid !== 1'b0 || b3.if_rdy !== 1'b0 || b3.if_inst !== 32'h0 || perr0 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_vals: busy=%b valid=%b rdy=%b inst=%08h perr0=%b want 1 0 0 00000000 0",
               busy3, b3.if_valid, b3.if_rdy, b3.if_inst, perr0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (b3.if_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_novalid%0d: valid=%b want 0", i, b3.if_valid);
      end
    end
    rst_n = 1'b1;
    $display("mid-wait reset released");
    wait_boot("boot_again");
    fetch3(6'h01, 32'h0, "cleared_01_dut3");
    fetch0(6'h01, 32'h0, "cleared_01_dut0");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_same_edge();
    test_parity();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
- Parametrised, synchronous instruction memory for the single-cycle and multi-cycle CPU cores.
- Successor to the fixed combinational instruction ROM.
- Contents are written at run time through a program-load port, after a hardware boot-clear fills every word with NOP (all zeros).
- Instructions are read through a request/valid fetch handshake with a configurable wait-state count, so the fetch stage can model slow memory.

Parameters:
- ADDR_W, 6: word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32: instruction width in bits.
- WAIT_CYC, 0: extra wait cycles per fetch, legal range 0..15.
- NOP_WORD, 32'h00000000: value written to every word during boot-clear.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- if_req, input, 1: fetch request.
- if_addr, input, ADDR_W: fetch word address.
- if_rdy, output, 1: fetch request accepted this cycle when if_req && if_rdy.
- if_valid, output, 1: one-cycle pulse; if_inst is valid.
- if_inst, output, DATA_W: fetched instruction, held until the next if_valid.
- ld_we, input, 1: program-load write strobe.
- ld_addr, input, ADDR_W: load address.
- ld_data, input, DATA_W: load data.
- ld_rdy, output, 1: load port accepting writes.
- busy, output, 1: boot-clear in progress.
- par_err, output, 1: parity error flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset values: if_rdy=0, if_valid=0, if_inst=NOP_WORD, ld_rdy=0, busy=1, par_err=0. The FSM enters BOOT and the clear counter is 0.
- FSM states: BOOT, IDLE, WAIT.
- BOOT:
  - Writes NOP_WORD to address clr_cnt and increments clr_cnt each cycle, for DEPTH cycles.
  - When clr_cnt == DEPTH-1 is written, go to IDLE. Next cycle busy=0, if_rdy=1, ld_rdy=1.
  - ld_we and if_req are ignored in BOOT; no response is generated.
- IDLE, on accept (if_req && if_rdy):
  - Latch if_addr.
  - If WAIT_CYC==0: the array is read at this edge and if_valid=1 next cycle. if_rdy stays 1, giving one fetch per cycle, fully pipelined.
  - If WAIT_CYC>0: go to WAIT, load wait counter = WAIT_CYC, if_rdy=0.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, read the latched address. if_valid=1 next cycle, return to IDLE, if_rdy=1 in that same valid cycle (a new request may be accepted concurrently).
- Latency from accept to if_valid is 1 + WAIT_CYC cycles.
- Load:
  - When ld_we && ld_rdy, write ld_data at the edge. Loads are accepted in IDLE and WAIT.
- Same-edge fetch read and load write to the same address: the read returns the OLD data (read-before-write). A later fetch returns the new data.
- if_req deasserted while a fetch is in WAIT: the fetch completes anyway; the response is not cancellable.
- Reset mid-operation (any state): immediate return to reset values and BOOT; memory is cleared again; any pending fetch is lost with no if_valid.
- Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits; the extra bit is the even-parity bit (XOR of the data), generated on load and on boot-clear.
  - On each read, parity is checked. par_err is asserted together with if_valid and is sticky until reset.
  - if_inst delivers the stored data unchanged.
- Undefined: no parity storage; par_err is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - Default widths: INST_W=32, IMEM_ADDR_W=6.
  - NOP_INST constant.
  - FSM state encoding: IMEM_BOOT=2'd0, IMEM_IDLE=2'd1, IMEM_WAIT=2'd2.
- One sub-module: imem_array, a plain synchronous single-port-write / single-port-read array with read-before-write. The FSM, counters and handshake stay in inst_mem_ctrl.

Test Plan:
- Reset release, defaults: busy=1 for exactly 64 cycles, then if_rdy=1 and ld_rdy=1. Fetch of 0x3F returns 32'h00000000.
- WAIT_CYC=0: load 0x01=32'h28033046 and 0x02=32'h00101464, then fetch 0x01, 0x02 back-to-back. Expect if_valid on two consecutive cycles with data 32'h28033046 then 32'h00101464.
- WAIT_CYC=3: fetch 0x05 holding 32'h3c000c21. Expect if_rdy=0 for 3 cycles and if_valid 4 cycles after accept. if_req dropped mid-wait still yields the response.
- Same edge: load 0x0A=32'h04100841 while fetching 0x0A (old 0). Expect if_inst=0; the next fetch returns 32'h04100841.
- Reset mid-WAIT: assert rst_n=0 during WAIT. Expect no if_valid, busy=1 again, and previously loaded 0x01 reads back 0 after boot.
- IMEM_PARITY_EN: force-flip a stored bit at 0x02, then fetch. Expect par_err=1 with if_valid, still 1 after later clean fetches until reset.
